// File: rtl/vedic_pkg.sv
// Shared definitions for the Vedic multiplier datapath and its
// dot-product accumulation stage: FSM state encoding, product width
// and the default-width result record.
package vedic_pkg;

    // Width of one unsigned product from the 16x16 multiplier.
    localparam int VEDIC_PROD_W = 32;

    // Default accumulator and term-counter widths.
    localparam int VEDIC_DOT_ACC_W = 48;
    localparam int VEDIC_DOT_CNT_W = 16;

    // Accumulator FSM: idle between vectors, or mid-vector.
    typedef enum logic [0:0] {
        DOT_IDLE = 1'b0,
        DOT_ACC  = 1'b1
    } dot_state_t;

    // One finished dot product at the default widths.
    typedef struct packed {
        logic [VEDIC_DOT_ACC_W-1:0] sum;
        logic [VEDIC_DOT_CNT_W-1:0] count;
        logic                       trunc;
        logic                       ovf;
    } dot_result_t;

endpackage

// File: rtl/vedic_dot_accum_if.sv
// Stream interface of the dot-product accumulator: product beats in,
// finished dot products out, each with its own valid/ready handshake.
interface vedic_dot_accum_if #(
    parameter int ACC_W = 48,
    parameter int CNT_W = 16
);
    import vedic_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic [VEDIC_PROD_W-1:0] in_prod;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic [ACC_W-1:0]        out_sum;
    logic [CNT_W-1:0]        out_count;
    logic                    out_trunc;
    logic                    out_ovf;

    // Producer of beats / consumer of results (e.g. a testbench).
    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_trunc, out_ovf
    );

    // The accumulator itself.
    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_trunc, out_ovf
    );

endinterface

// File: rtl/vedic_dot_outbuf.sv
// One-entry valid/ready register slice holding a finished result.
// It owns the upstream ready term: new data may be loaded whenever the
// slot is empty or is being drained in the same cycle.
module vedic_dot_outbuf
    import vedic_pkg::*;
#(
    parameter type T = dot_result_t
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  T     load_data,
    input  logic out_ready,
    output logic in_ready,
    output logic out_valid,
    output T     out_data
);

    logic valid_r;
    T     data_r;

    assign in_ready  = !valid_r || out_ready;
    assign out_valid = valid_r;
    assign out_data  = data_r;

    // Slot occupancy and payload; a load wins over a drain in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= load_data;
        end else if (out_ready) begin
            valid_r <= 1'b0;
            data_r  <= data_r;
        end else begin
            valid_r <= valid_r;
            data_r  <= data_r;
        end
    end

endmodule

// File: rtl/vedic_dot_accum.sv
// Dot-product accumulator behind the registered 16x16 Vedic multiplier.
// Sums one 32-bit product per cycle into an ACC_W-bit accumulator,
// closes a vector on in_last or after MAX_TERMS terms, and hands the
// result to a one-entry output buffer.
// Build option VEDIC_DOT_ACC_SAT_EN: clamp the accumulator to all ones on
// carry instead of wrapping modulo 2^ACC_W.
module vedic_dot_accum
    import vedic_pkg::*;
#(
    parameter int ACC_W     = 48,
    parameter int CNT_W     = 16,
    parameter int MAX_TERMS = 65535
) (
    input  logic              clk,
    input  logic              rst,
    vedic_dot_accum_if.slave  bus
);

    typedef struct packed {
        logic [ACC_W-1:0] sum;
        logic [CNT_W-1:0] count;
        logic             trunc;
        logic             ovf;
    } res_t;

    // Counter value of the last permitted term of a vector.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_TERMS - 1);

    dot_state_t       state_r;
    dot_state_t       state_nx_s;
    logic [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             ovf_r;

    logic             in_ready_s;
    logic             accept_s;
    logic             close_s;
    logic [ACC_W:0]   sum_wide_s;
    logic             carry_s;
    logic [ACC_W-1:0] acc_next_s;
    res_t             res_s;
    res_t             res_q;

    assign accept_s   = bus.in_valid && in_ready_s;
    assign close_s    = bus.in_last || (cnt_r == LAST_IDX);
    assign sum_wide_s = {1'b0, acc_r}
                      + {{(ACC_W + 1 - VEDIC_PROD_W){1'b0}}, bus.in_prod};
    assign carry_s    = sum_wide_s[ACC_W];

`ifdef VEDIC_DOT_ACC_SAT_EN
    // Saturating add: once clamped, further positive terms keep carrying,
    // so the accumulator stays at all ones for the rest of the vector.
    assign acc_next_s = carry_s ? {ACC_W{1'b1}} : sum_wide_s[ACC_W-1:0];
`else
    // Wrapping add modulo 2^ACC_W; the carry is still recorded in ovf_r.
    assign acc_next_s = sum_wide_s[ACC_W-1:0];
`endif

    // Result record presented to the output buffer on a closing beat.
    always_comb begin
        res_s       = '0;
        res_s.sum   = acc_next_s;
        res_s.count = cnt_r + CNT_W'(1);
        res_s.trunc = !bus.in_last;
        res_s.ovf   = ovf_r | carry_s;
    end

    // Next-state logic: any closing beat returns to idle, any other
    // accepted beat means a vector is in progress.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            DOT_IDLE: begin
                if (accept_s && !close_s) begin
                    state_nx_s = DOT_ACC;
                end else begin
                    state_nx_s = DOT_IDLE;
                end
            end
            DOT_ACC: begin
                if (accept_s && close_s) begin
                    state_nx_s = DOT_IDLE;
                end else begin
                    state_nx_s = DOT_ACC;
                end
            end
            default: begin
                state_nx_s = DOT_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= DOT_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Accumulator, term counter and sticky overflow; cleared when a vector closes.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= '0;
            cnt_r <= '0;
            ovf_r <= 1'b0;
        end else if (accept_s && close_s) begin
            acc_r <= '0;
            cnt_r <= '0;
            ovf_r <= 1'b0;
        end else if (accept_s) begin
            acc_r <= acc_next_s;
            cnt_r <= cnt_r + CNT_W'(1);
            ovf_r <= ovf_r | carry_s;
        end else begin
            acc_r <= acc_r;
            cnt_r <= cnt_r;
            ovf_r <= ovf_r;
        end
    end

    vedic_dot_outbuf #(
        .T (res_t)
    ) u_outbuf (
        .clk       (clk),
        .rst       (rst),
        .load      (accept_s && close_s),
        .load_data (res_s),
        .out_ready (bus.out_ready),
        .in_ready  (in_ready_s),
        .out_valid (bus.out_valid),
        .out_data  (res_q)
    );

    assign bus.in_ready  = in_ready_s;
    assign bus.out_sum   = res_q.sum;
    assign bus.out_count = res_q.count;
    assign bus.out_trunc = res_q.trunc;
    assign bus.out_ovf   = res_q.ovf;

endmodule

// File: tb/tb_vedic_dot_accum.sv
// Directed bench for vedic_dot_accum, built with ACC_W=33 and MAX_TERMS=4
// so that the wide-carry and forced-length cases are reachable quickly.
module tb_vedic_dot_accum;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    vedic_dot_accum_if #(.ACC_W(33), .CNT_W(16)) bus ();

    vedic_dot_accum #(
        .ACC_W     (33),
        .CNT_W     (16),
        .MAX_TERMS (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] p, input logic l, input logic r);
        bus.in_valid  = v;
        bus.in_prod   = p;
        bus.in_last   = l;
        bus.out_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_res(input string tag, input logic [63:0] sum,
                             input logic [63:0] cnt, input logic tr, input logic ov);
        check({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, ".sum"},   64'(bus.out_sum),   sum);
        check({tag, ".count"}, 64'(bus.out_count), cnt);
        check({tag, ".trunc"}, 64'(bus.out_trunc), 64'(tr));
        check({tag, ".ovf"},   64'(bus.out_ovf),   64'(ov));
    endtask

    logic [31:0] singles [3];
    logic [63:0] sat_exp;

    initial begin
        singles[0] = 32'd5;
        singles[1] = 32'd7;
        singles[2] = 32'd9;
`ifdef VEDIC_DOT_ACC_SAT_EN
        sat_exp = 64'h1_FFFF_FFFF;
`else
        sat_exp = 64'h0_FFFF_FFFD;
`endif

        // Reset state
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        tick();
        check("rst.in_ready",  64'(bus.in_ready),  64'd1);
        check("rst.out_valid", 64'(bus.out_valid), 64'd0);
        check("rst.out_sum",   64'(bus.out_sum),   64'd0);
        check("rst.out_count", 64'(bus.out_count), 64'd0);
        check("rst.flags",     64'({bus.out_trunc, bus.out_ovf}), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst.in_ready", 64'(bus.in_ready), 64'd1);

        // Three-term vector
        drive(1'b1, 32'd6, 1'b0, 1'b1);
        tick();
        check("v3.no_early_valid", 64'(bus.out_valid), 64'd0);
        drive(1'b1, 32'd35, 1'b0, 1'b1);
        tick();
        drive(1'b1, 32'hFFFE_0001, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        check_res("v3", 64'h0_FFFE_002A, 64'd3, 1'b0, 1'b0);
        tick();
        check("v3.drained", 64'(bus.out_valid), 64'd0);

        // Back-to-back single-term vectors
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, singles[i], 1'b1, 1'b1);
            #1;
            check("single.in_ready", 64'(bus.in_ready), 64'd1);
            tick();
            check_res("single", 64'(singles[i]), 64'd1, 1'b0, 1'b0);
        end
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        tick();
        check("single.drained", 64'(bus.out_valid), 64'd0);

        // Backpressure: result held, input stalled for 4 cycles
        drive(1'b1, 32'd10, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'd20, 1'b1, 1'b0);
            #1;
            check("bp.in_ready", 64'(bus.in_ready), 64'd0);
            check_res("bp.hold", 64'd10, 64'd1, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'd20, 1'b1, 1'b1);
        #1;
        check("bp.release_ready", 64'(bus.in_ready), 64'd1);
        tick();
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        check_res("bp.reload", 64'd20, 64'd1, 1'b0, 1'b0);
        tick();
        check("bp.drained", 64'(bus.out_valid), 64'd0);

        // Forced length: six beats of 1, in_last only on the sixth
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 32'd1, (i == 6), 1'b1);
            tick();
            if (i == 3) check("max.not_yet", 64'(bus.out_valid), 64'd0);
            if (i == 4) check_res("max.trunc", 64'd4, 64'd4, 1'b1, 1'b0);
            if (i == 5) check("max.gap", 64'(bus.out_valid), 64'd0);
            if (i == 6) check_res("max.tail", 64'd2, 64'd2, 1'b0, 1'b0);
        end

        // in_last on the MAX_TERMS-th beat is a normal close
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 32'd2, (i == 4), 1'b1);
            tick();
        end
        check_res("max.last", 64'd8, 64'd4, 1'b0, 1'b0);

        // Carry out of 33 bits
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 32'hFFFF_FFFF, (i == 3), 1'b1);
            tick();
        end
        check_res("ovf", sat_exp, 64'd3, 1'b0, 1'b1);
        drive(1'b1, 32'd1, 1'b1, 1'b1);
        tick();
        check_res("ovf.cleared", 64'd1, 64'd1, 1'b0, 1'b0);

        // Reset mid-vector discards the partial sum
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'd100, 1'b0, 1'b1);
            tick();
        end
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b1, 32'd3, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        check_res("rst_mid", 64'd3, 64'd1, 1'b0, 1'b0);
        tick();

        // Reset drops a pending, undrained result
        drive(1'b1, 32'd77, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        check_res("pend", 64'd77, 64'd1, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("pend.dropped", 64'(bus.out_valid), 64'd0);
        check("pend.sum_clr", 64'(bus.out_sum),   64'd0);
        check("pend.in_ready", 64'(bus.in_ready), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
